// File: rtl/clk_step_ctrl.sv
// rtl/clk_step_ctrl.sv - run/halt/single-step processor clock controller with programmable divider
// Optional tick counter on cyc_cnt enabled by CLK_STEP_CYC_COUNT_EN.
module clk_step_ctrl #(
    parameter int          DIV_W   = 26,
    parameter int unsigned DEF_DIV = 10000000,
    parameter int unsigned DEB_CNT = 500000
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             clkout,
    output logic             tick,
    output logic [1:0]       state,
    output logic [31:0]      cyc_cnt
);

    localparam int               DEB_W     = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);

    typedef enum logic [1:0] {
        S_HALT    = 2'b00,
        S_RUN     = 2'b01,
        S_STEP_HI = 2'b10,
        S_STEP_LO = 2'b11
    } state_t;

    state_t           st;
    logic             run_s1, run_s;
    logic             btn_s1, btn_s;
    logic             btn_db;
    logic [DEB_W-1:0] deb_cnt;
    logic [DIV_W-1:0] cnt, div_q, pend_q;
    logic             pend_v;

    logic             step_evt;
    logic             term;
    logic             stop;
    logic             go_run;
    logic             go_step;
    logic             rise;
    logic [DIV_W-1:0] div_nz;

    assign state = st;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            run_s1 <= 1'b0;
            run_s  <= 1'b0;
            btn_s1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            run_s1 <= run_sw;
            run_s  <= run_s1;
            btn_s1 <= step_btn;
            btn_s  <= btn_s1;
        end
    end

    // A new button level is accepted on its DEB_CNT-th consecutive cycle; only 0->1 is a step.
    assign step_evt = (btn_s != btn_db) && (deb_cnt == DEB_LAST) && btn_s;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign div_nz  = (div_val == '0) ? DIV_W'(1) : div_val;
    assign term    = (cnt == div_q - DIV_W'(1));
    assign stop    = !run_s || halt_req;
    assign go_run  = run_s && !halt_req;
    assign go_step = step_evt && !run_s;
    assign rise    = ((st == S_HALT) && (go_run || go_step))
                   || ((st == S_RUN) && term && !clkout && !stop);

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            st     <= S_HALT;
            clkout <= 1'b0;
            tick   <= 1'b0;
            cnt    <= '0;
        end else begin
            tick <= 1'b0;
            case (st)
                S_HALT: begin
                    cnt <= '0;
                    if (go_run) begin
                        st     <= S_RUN;
                        clkout <= 1'b1;
                        tick   <= 1'b1;
                    end else if (go_step) begin
                        st     <= S_STEP_HI;
                        clkout <= 1'b1;
                        tick   <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= term ? '0 : cnt + DIV_W'(1);
                    // Stop is only honoured at the end of a low phase, so periods are never cut.
                    if (term) begin
                        if (clkout) begin
                            clkout <= 1'b0;
                        end else if (stop) begin
                            st <= S_HALT;
                        end else begin
                            clkout <= 1'b1;
                            tick   <= 1'b1;
                        end
                    end
                end
                S_STEP_HI: begin
                    cnt <= term ? '0 : cnt + DIV_W'(1);
                    if (term) begin
                        clkout <= 1'b0;
                        st     <= S_STEP_LO;
                    end
                end
                S_STEP_LO: begin
                    cnt <= term ? '0 : cnt + DIV_W'(1);
                    if (term) begin
                        st <= S_HALT;
                    end
                end
                default: st <= S_HALT;
            endcase
        end
    end

    // While clocking, a new half-period waits for the next rising edge of clkout.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            div_q  <= DEF_DIV_V;
            pend_q <= '0;
            pend_v <= 1'b0;
        end else if ((st == S_HALT) && div_load) begin
            div_q  <= div_nz;
            pend_v <= 1'b0;
        end else begin
            if (rise && pend_v) begin
                div_q  <= pend_q;
                pend_v <= 1'b0;
            end
            if (div_load) begin
                pend_q <= div_nz;
                pend_v <= 1'b1;
            end
        end
    end

`ifdef CLK_STEP_CYC_COUNT_EN
    logic [31:0] cyc_q;

    // Counted on the same edge that raises tick so both outputs move together.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= '0;
        end else if (rise) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cyc_cnt = cyc_q;
`else
    assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb/tb_clk_step_ctrl.sv - self-checking bench for clk_step_ctrl (DEF_DIV=3, DEB_CNT=4)
// Honours CLK_STEP_CYC_COUNT_EN for the expected cyc_cnt.
module tb_clk_step_ctrl;

    localparam int DIV_W   = 26;
    localparam int DEF_DIV = 3;
    localparam int DEB_CNT = 4;

    logic             clkin    = 1'b0;
    logic             rstn     = 1'b1;
    logic             run_sw   = 1'b0;
    logic             step_btn = 1'b0;
    logic             halt_req = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             clkout;
    logic             tick;
    logic [1:0]       state;
    logic [31:0]      cyc_cnt;

    int n_run  = 0;
    int n_fail = 0;

    clk_step_ctrl #(
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV),
        .DEB_CNT(DEB_CNT)
    ) dut (
        .clkin   (clkin),
        .rstn    (rstn),
        .run_sw  (run_sw),
        .step_btn(step_btn),
        .halt_req(halt_req),
        .div_load(div_load),
        .div_val (div_val),
        .clkout  (clkout),
        .tick    (tick),
        .state   (state),
        .cyc_cnt (cyc_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: phase-length bookkeeping (cycles left in the current half-period) per operator rules.
    int          m_state = 0;
    bit          m_clk   = 0;
    bit          m_tick  = 0;
    int          m_left  = 0;
    int          m_div   = DEF_DIV;
    int          m_pend  = 0;
    bit          m_pv    = 0;
    logic [31:0] m_cyc   = '0;
    bit          rs1 = 0, rs2 = 0, bs1 = 0, bs2 = 0, lvl = 0;
    int          same = 0;
    bit          m_run_s, m_btn_s, m_step, m_rise, m_was_halt;
    int          m_nz;

    always @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            m_state = 0; m_clk = 0; m_tick = 0; m_left = 0;
            m_div = DEF_DIV; m_pend = 0; m_pv = 0; m_cyc = '0;
            rs1 = 0; rs2 = 0; bs1 = 0; bs2 = 0; lvl = 0; same = 0;
        end else begin
            m_run_s = rs2; m_btn_s = bs2;
            rs2 = rs1; rs1 = run_sw; bs2 = bs1; bs1 = step_btn;
            m_step = 0;
            if (m_btn_s != lvl) begin
                same++;
                if (same == DEB_CNT) begin
                    lvl = m_btn_s; same = 0; m_step = lvl;
                end
            end else begin
                same = 0;
            end
            m_nz = (div_val == '0) ? 1 : int'(div_val);
            m_tick = 0; m_rise = 0;
            m_was_halt = (m_state == 0);
            if (m_was_halt) begin
                if (div_load) begin m_div = m_nz; m_pv = 0; end
                if (m_run_s && !halt_req) begin m_state = 1; m_rise = 1; end
                else if (m_step && !m_run_s) begin m_state = 2; m_rise = 1; end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_state == 1) begin
                        if (m_clk) begin m_clk = 0; m_left = m_div; end
                        else if (!m_run_s || halt_req) m_state = 0;
                        else m_rise = 1;
                    end else if (m_state == 2) begin
                        m_clk = 0; m_state = 3; m_left = m_div;
                    end else begin
                        m_state = 0;
                    end
                end
            end
            if (m_rise) begin
                if (m_pv) begin m_div = m_pend; m_pv = 0; end
                m_clk = 1; m_tick = 1; m_left = m_div;
`ifdef CLK_STEP_CYC_COUNT_EN
                m_cyc = m_cyc + 32'd1;
`endif
            end
            if (!m_was_halt && div_load) begin m_pend = m_nz; m_pv = 1; end
        end
    end

    always @(negedge clkin) begin
        chk("clkout", 64'(clkout), 64'(m_clk));
        chk("tick", 64'(tick), 64'(m_tick));
        chk("state", 64'(state), 64'(m_state));
        chk("cyc_cnt", 64'(cyc_cnt), 64'(m_cyc));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic wait_tick(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clkin);
            k++;
        end while (tick !== 1'b1 && k < budget);
        n_run++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no tick within %0d cycles", name, budget);
        end
    endtask

    task automatic count_win(input int n, output int ticks, output int highs);
        ticks = 0;
        highs = 0;
        repeat (n) begin
            @(negedge clkin);
            ticks += int'(tick);
            highs += int'(clkout);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t1, h1, t2, h2, t3, h3;
        #1 rstn = 1'b0;
        cyc(3);
        chk("reset_clkout", 64'(clkout), 64'd0);
        chk("reset_tick", 64'(tick), 64'd0);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_cyc", 64'(cyc_cnt), 64'd0);
        rstn = 1'b1;
        cyc(2);

        // free run: rise 3 cycles after run_sw, then 3 high / 3 low
        run_sw = 1'b1;
        cyc(3);
        chk("run_first_clk", 64'(clkout), 64'd1);
        chk("run_first_tick", 64'(tick), 64'd1);
        count_win(12, t1, h1);
        chk("run_ticks_12", 64'(t1), 64'd2);
        chk("run_highs_12", 64'(h1), 64'd6);

        // drop run_sw right after a rise: phase completes, no more ticks
        run_sw = 1'b0;
        count_win(12, t1, h1);
        chk("stop_sw_ticks", 64'(t1), 64'd0);
        chk("stop_sw_highs", 64'(h1), 64'd2);
        chk("stop_sw_state", 64'(state), 64'd0);

        run_sw = 1'b1;
        wait_tick("halt_start", 12);
        halt_req = 1'b1;
        count_win(12, t1, h1);
        chk("stop_hr_ticks", 64'(t1), 64'd0);
        chk("stop_hr_highs", 64'(h1), 64'd2);
        chk("stop_hr_state", 64'(state), 64'd0);
        cyc(6);
        chk("hr_blocks_run", 64'(state), 64'd0);
        halt_req = 1'b0;
        cyc(1);
        chk("hr_release_state", 64'(state), 64'd1);
        chk("hr_release_tick", 64'(tick), 64'd1);
        run_sw = 1'b0;
        cyc(20);
        chk("run_off_state", 64'(state), 64'd0);

        // glitch then a clean press: one full period
        step_btn = 1'b1;
        count_win(2, t1, h1);
        step_btn = 1'b0;
        count_win(6, t2, h2);
        chk("glitch_ticks", 64'(t1 + t2), 64'd0);
        step_btn = 1'b1;
        count_win(10, t1, h1);
        step_btn = 1'b0;
        count_win(14, t2, h2);
        chk("step_ticks", 64'(t1 + t2), 64'd1);
        chk("step_highs", 64'(h1 + h2), 64'd3);
        chk("step_end_state", 64'(state), 64'd0);

        // halt_req does not block or cut a step
        halt_req = 1'b1;
        step_btn = 1'b1;
        count_win(8, t1, h1);
        step_btn = 1'b0;
        count_win(14, t2, h2);
        halt_req = 1'b0;
        chk("step_hr_ticks", 64'(t1 + t2), 64'd1);
        chk("step_hr_highs", 64'(h1 + h2), 64'd3);

        // div_load mid-low: current low stays 3, next period is 5/5
        run_sw = 1'b1;
        wait_tick("div_start", 12);
        cyc(4);
        chk("div_midlow_clk", 64'(clkout), 64'd0);
        div_load = 1'b1;
        div_val  = DIV_W'(5);
        cyc(1);
        div_load = 1'b0;
        cyc(1);
        chk("div_low3_tick", 64'(tick), 64'd1);
        count_win(10, t1, h1);
        chk("div5_ticks", 64'(t1), 64'd1);
        chk("div5_highs", 64'(h1), 64'd5);
        run_sw = 1'b0;
        cyc(30);
        chk("div5_halt", 64'(state), 64'd0);

        // div_val 0 behaves as 1
        div_load = 1'b1;
        div_val  = '0;
        cyc(1);
        div_load = 1'b0;
        step_btn = 1'b1;
        count_win(8, t1, h1);
        step_btn = 1'b0;
        count_win(10, t2, h2);
        chk("div0_ticks", 64'(t1 + t2), 64'd1);
        chk("div0_highs", 64'(h1 + h2), 64'd1);

        // reset mid-high
        run_sw = 1'b1;
        wait_tick("rst_start", 12);
        #2;
        rstn   = 1'b0;
        run_sw = 1'b0;
        #1;
        chk("rst_mid_clk", 64'(clkout), 64'd0);
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_cyc", 64'(cyc_cnt), 64'd0);
        @(negedge clkin);
        rstn = 1'b1;
        cyc(2);

        // seven steps from reset
        t3 = 0;
        h3 = 0;
        for (int i = 0; i < 7; i++) begin
            step_btn = 1'b1;
            count_win(8, t1, h1);
            step_btn = 1'b0;
            count_win(10, t2, h2);
            t3 += t1 + t2;
            h3 += h1 + h2;
        end
        cyc(5);
        chk("steps7_ticks", 64'(t3), 64'd7);
        chk("steps7_highs", 64'(h3), 64'd21);
`ifdef CLK_STEP_CYC_COUNT_EN
        chk("steps7_cyc", 64'(cyc_cnt), 64'd7);
`else
        chk("steps7_cyc", 64'(cyc_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
